controle_entrada_tempo: RTL and testbench

CONTROLE_ENTRADA_TEMPO -- requirements
Module: controle_entrada_tempo

---
 rtl/controle_entrada_tempo_pkg.sv | 27 ++
 rtl/controle_entrada_tempo_codificador_priori.sv | 36 +++
 rtl/controle_entrada_tempo.sv | 133 +++++++++++++
 tb/tb_controle_entrada_tempo.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/controle_entrada_tempo_pkg.sv
// Shared definitions for the microwave keypad time-entry block.
// Holds FSM states, the default debounce length and the BCD digit width.
package controle_entrada_tempo_pkg;

  localparam int DEB_CICLOS_PADRAO = 4;
  localparam int BCD_W             = 4;
  localparam int N_TECLAS          = 10;
  localparam int N_DIGITOS         = 4;
  localparam int CNT_W             = 4;
  localparam int TEMPO_W           = N_DIGITOS * BCD_W;

  typedef enum logic [1:0] {
    OCIOSO        = 2'd0,
    DEBOUNCE      = 2'd1,
    CAPTURA       = 2'd2,
    ESPERA_SOLTAR = 2'd3
  } estado_t;

  typedef logic [BCD_W-1:0]   bcd_t;
  typedef logic [TEMPO_W-1:0] tempo_t;

  // New digit enters on the right (seconds units); the leftmost digit falls off.
  function automatic tempo_t desloca_digito(input tempo_t tempo, input bcd_t digito);
    return {tempo[TEMPO_W-BCD_W-1:0], digito};
  endfunction

endpackage

// File: rtl/controle_entrada_tempo_codificador_priori.sv
// Priority encoder for the 10-line keypad: the highest active index wins.
// valido_o is suppressed while enablen_i is high.
module codificador_priori
  import controle_entrada_tempo_pkg::*;
(
  input  logic [N_TECLAS-1:0] teclado_i,
  input  logic                enablen_i,
  output bcd_t                codigo_o,
  output logic                valido_o
);

  logic [N_TECLAS-1:0] sel;

  // sel is one-hot: a line is selected only when no higher line is active.
  generate
    for (genvar gi = 0; gi < N_TECLAS; gi++) begin : g_sel
      if (gi == N_TECLAS - 1) begin : g_topo
        assign sel[gi] = teclado_i[gi];
      end else begin : g_resto
        assign sel[gi] = teclado_i[gi] & ~(|teclado_i[N_TECLAS-1:gi+1]);
      end
    end
  endgenerate

  always_comb begin
    codigo_o = '0;
    for (int i = 0; i < N_TECLAS; i++) begin
      if (sel[i]) begin
        codigo_o = codigo_o | BCD_W'(i);
      end
    end
  end

  assign valido_o = ~enablen_i & (|teclado_i);

endmodule

// File: rtl/controle_entrada_tempo.sv
// Keypad time entry: debounces key press and release, then shifts the
// captured BCD digit into a 4-digit mm:ss register.
module controle_entrada_tempo
  import controle_entrada_tempo_pkg::*;
#(
  parameter int DEB_CICLOS = DEB_CICLOS_PADRAO
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_TECLAS-1:0] teclado,
  input  logic                enablen,
  input  logic                limpar,
  output logic [TEMPO_W-1:0]  tempo_bcd,
  output logic [BCD_W-1:0]    tecla_bcd,
  output logic                digito_pronto,
  output logic                tempo_zero,
  output logic                tempo_invalido
);

  localparam logic [CNT_W-1:0] CNT_ALVO = CNT_W'(DEB_CICLOS);

  estado_t          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_mais;
  bcd_t             codigo_q, codigo_d;
  tempo_t           tempo_q, tempo_d;
  bcd_t             tecla_q, tecla_d;
  logic             pronto_q, pronto_d;

  bcd_t             codigo_atual;
  logic             tecla_valida;

  codificador_priori u_codificador (
    .teclado_i (teclado),
    .enablen_i (enablen),
    .codigo_o  (codigo_atual),
    .valido_o  (tecla_valida)
  );

  assign cnt_mais = cnt_q + CNT_W'(1);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    codigo_d = codigo_q;
    tempo_d  = tempo_q;
    tecla_d  = tecla_q;
    pronto_d = 1'b0;

    case (state_q)
      OCIOSO: begin
        if (tecla_valida) begin
          codigo_d = codigo_atual;
          cnt_d    = CNT_W'(1);
          state_d  = DEBOUNCE;
        end else begin
          cnt_d = '0;
        end
      end

      DEBOUNCE: begin
        if (!tecla_valida) begin
          cnt_d   = '0;
          state_d = OCIOSO;
        end else if (codigo_atual == codigo_q) begin
          cnt_d = cnt_mais;
          if (cnt_mais == CNT_ALVO) begin
            state_d = CAPTURA;
          end
        end else begin
          // A different key restarts the debounce window on the new code.
          codigo_d = codigo_atual;
          cnt_d    = CNT_W'(1);
        end
      end

      CAPTURA: begin
        tempo_d  = desloca_digito(tempo_q, codigo_q);
        tecla_d  = codigo_q;
        pronto_d = 1'b1;
        cnt_d    = '0;
        state_d  = ESPERA_SOLTAR;
      end

      ESPERA_SOLTAR: begin
        // Release is judged on the raw lines, so enablen cannot shorten it.
        if (teclado == '0) begin
          if (cnt_mais == CNT_ALVO) begin
            cnt_d   = '0;
            state_d = OCIOSO;
          end else begin
            cnt_d = cnt_mais;
          end
        end else begin
          cnt_d = '0;
        end
      end

      default: begin
        cnt_d   = '0;
        state_d = OCIOSO;
      end
    endcase

    if (limpar) begin
      tempo_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= OCIOSO;
      cnt_q    <= '0;
      codigo_q <= '0;
      tempo_q  <= '0;
      tecla_q  <= '0;
      pronto_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      codigo_q <= codigo_d;
      tempo_q  <= tempo_d;
      tecla_q  <= tecla_d;
      pronto_q <= pronto_d;
    end
  end

  assign tempo_bcd      = tempo_q;
  assign tecla_bcd      = tecla_q;
  assign digito_pronto  = pronto_q;
  assign tempo_zero     = (tempo_q == '0);
  assign tempo_invalido = (tempo_q[2*BCD_W-1:BCD_W] > BCD_W'(5));

endmodule

// File: tb/tb_controle_entrada_tempo.sv
// Bench for controle_entrada_tempo: directed scenarios plus randomized
// keypad traffic compared against a run-length reference model.
module tb_controle_entrada_tempo;

  localparam int DEB = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [9:0]  teclado = '0;
  logic        enablen = 1'b0;
  logic        limpar = 1'b0;
  logic [15:0] tempo_bcd;
  logic [3:0]  tecla_bcd;
  logic        digito_pronto;
  logic        tempo_zero;
  logic        tempo_invalido;

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  // Reference model: counts runs of qualifying samples.
  logic [15:0] m_tempo;
  logic [3:0]  m_tecla;
  logic        m_pronto;
  bit          m_release;
  bit          m_pend;
  int          m_run;
  int          m_code;

  always #5 clk = ~clk;

  controle_entrada_tempo #(.DEB_CICLOS(DEB)) dut (
    .clk            (clk),
    .reset          (reset),
    .teclado        (teclado),
    .enablen        (enablen),
    .limpar         (limpar),
    .tempo_bcd      (tempo_bcd),
    .tecla_bcd      (tecla_bcd),
    .digito_pronto  (digito_pronto),
    .tempo_zero     (tempo_zero),
    .tempo_invalido (tempo_invalido)
  );

  function automatic int maior_tecla(input logic [9:0] t);
    int r = -1;
    for (int i = 0; i < 10; i++) if (t[i]) r = i;
    return r;
  endfunction

  task automatic model_reset();
    m_tempo = '0; m_tecla = '0; m_pronto = 1'b0;
    m_release = 0; m_pend = 0; m_run = 0; m_code = 0;
  endtask

  task automatic model_step();
    int k;
    m_pronto = m_pend;
    if (m_pend) begin
      m_tecla   = 4'(m_code);
      m_tempo   = limpar ? 16'h0000 : {m_tempo[11:0], 4'(m_code)};
      m_pend    = 0;
      m_release = 1;
      m_run     = 0;
    end else begin
      if (limpar) m_tempo = '0;
      if (m_release) begin
        if (teclado == 0) begin
          m_run++;
          if (m_run == DEB) begin m_release = 0; m_run = 0; end
        end else m_run = 0;
      end else begin
        k = (enablen == 1'b0) ? maior_tecla(teclado) : -1;
        if (k < 0) m_run = 0;
        else if (m_run > 0 && k == m_code) m_run++;
        else begin m_code = k; m_run = 1; end
        if (m_run == DEB) m_pend = 1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    if (digito_pronto) pulses++;
  endtask

  task automatic test_reset();
    #2 reset = 1'b1;
    #1;
    model_reset();
    checks++; if (tempo_bcd !== 16'h0000) begin errors++; $display("FAIL reset_tempo: got %h expected 0000", tempo_bcd); end
    checks++; if (tecla_bcd !== 4'h0) begin errors++; $display("FAIL reset_tecla: got %h expected 0", tecla_bcd); end
    checks++; if (digito_pronto !== 1'b0) begin errors++; $display("FAIL reset_pronto: got %b expected 0", digito_pronto); end
    checks++; if (tempo_zero !== 1'b1) begin errors++; $display("FAIL reset_zero: got %b expected 1", tempo_zero); end
    @(posedge clk);
    #2 reset = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_single_key();
    int first = -1;
    pulses = 0;
    teclado = 10'b1 << 5;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (digito_pronto && first < 0) first = i;
      checks++; if (digito_pronto !== m_pronto) begin errors++; $display("FAIL single_pronto t%0d: got %b expected %b", i, digito_pronto, m_pronto); end
    end
    checks++; if (pulses != 1) begin errors++; $display("FAIL single_pulses: got %0d expected 1", pulses); end
    checks++; if (first != DEB) begin errors++; $display("FAIL single_latency: got %0d expected %0d", first, DEB); end
    checks++; if (tempo_bcd !== 16'h0005) begin errors++; $display("FAIL single_tempo: got %h expected 0005", tempo_bcd); end
    checks++; if (tecla_bcd !== 4'd5) begin errors++; $display("FAIL single_tecla: got %h expected 5", tecla_bcd); end
    teclado = '0;
    repeat (6) tick();
    $display("test_single_key: tempo=%h tecla=%h pulses=%0d", tempo_bcd, tecla_bcd, pulses);
  endtask

  task automatic test_sequence();
    int keys[5] = '{1, 2, 3, 0, 9};
    foreach (keys[j]) begin
      teclado = 10'b1 << keys[j];
      repeat (6) tick();
      teclado = '0;
      repeat (6) tick();
      checks++; if (tempo_bcd !== m_tempo) begin errors++; $display("FAIL seq_step%0d: got %h expected %h", j, tempo_bcd, m_tempo); end
    end
    checks++; if (tempo_bcd !== 16'h2309) begin errors++; $display("FAIL seq_tempo: got %h expected 2309", tempo_bcd); end
    checks++; if (tempo_invalido !== 1'b0) begin errors++; $display("FAIL seq_invalido: got %b expected 0", tempo_invalido); end
    $display("test_sequence: tempo=%h", tempo_bcd);
  endtask

  task automatic test_bounce();
    pulses = 0;
    teclado = 10'b1 << 7; repeat (2) tick();
    teclado = '0;         repeat (1) tick();
    teclado = 10'b1 << 7; repeat (8) tick();
    teclado = '0;         repeat (6) tick();
    checks++; if (pulses != 1) begin errors++; $display("FAIL bounce_pulses: got %0d expected 1", pulses); end
    checks++; if (tempo_bcd !== 16'h3097) begin errors++; $display("FAIL bounce_tempo: got %h expected 3097", tempo_bcd); end
    checks++; if (tecla_bcd !== 4'd7) begin errors++; $display("FAIL bounce_tecla: got %h expected 7", tecla_bcd); end
    teclado = 10'b1 << 2; repeat (DEB - 1) tick();
    teclado = '0;         repeat (6) tick();
    checks++; if (pulses != 1) begin errors++; $display("FAIL glitch_pulses: got %0d expected 1", pulses); end
    checks++; if (tempo_bcd !== m_tempo) begin errors++; $display("FAIL glitch_tempo: got %h expected %h", tempo_bcd, m_tempo); end
    $display("test_bounce: tempo=%h pulses=%0d", tempo_bcd, pulses);
  endtask

  task automatic test_priority();
    teclado = 10'b1000001001; repeat (8) tick();
    teclado = '0;             repeat (6) tick();
    checks++; if (tecla_bcd !== 4'd9) begin errors++; $display("FAIL prio_tecla: got %h expected 9", tecla_bcd); end
    checks++; if (tempo_bcd !== 16'h0979) begin errors++; $display("FAIL prio_tempo: got %h expected 0979", tempo_bcd); end
    $display("test_priority: tecla=%h tempo=%h", tecla_bcd, tempo_bcd);
  endtask

  task automatic test_enable();
    pulses = 0;
    enablen = 1'b1; teclado = 10'b1 << 4; repeat (10) tick();
    enablen = 1'b0; teclado = '0;         repeat (6) tick();
    checks++; if (pulses != 0) begin errors++; $display("FAIL en_pulses: got %0d expected 0", pulses); end
    teclado = 10'b1 << 4; repeat (2) tick();
    enablen = 1'b1;       repeat (4) tick();
    enablen = 1'b0; teclado = '0; repeat (6) tick();
    checks++; if (pulses != 0) begin errors++; $display("FAIL en_drop_pulses: got %0d expected 0", pulses); end
    checks++; if (tempo_bcd !== 16'h0979) begin errors++; $display("FAIL en_tempo: got %h expected 0979", tempo_bcd); end
    // enablen high while waiting for release must not end the release wait
    teclado = 10'b1 << 6; repeat (6) tick();
    enablen = 1'b1;       repeat (3) tick();
    teclado = '0;         repeat (DEB - 1) tick();
    enablen = 1'b0; teclado = 10'b1 << 1; repeat (6) tick();
    teclado = '0; repeat (6) tick();
    checks++; if (pulses != 1) begin errors++; $display("FAIL en_release_pulses: got %0d expected 1", pulses); end
    checks++; if (tempo_bcd !== 16'h9796) begin errors++; $display("FAIL en_release_tempo: got %h expected 9796", tempo_bcd); end
    $display("test_enable: tempo=%h pulses=%0d", tempo_bcd, pulses);
  endtask

  task automatic test_limpar_reset();
    int first = -1;
    teclado = 10'b1 << 3; repeat (DEB) tick();
    limpar = 1'b1; tick(); limpar = 1'b0;
    checks++; if (digito_pronto !== 1'b1) begin errors++; $display("FAIL clr_pronto: got %b expected 1", digito_pronto); end
    checks++; if (tempo_bcd !== 16'h0000) begin errors++; $display("FAIL clr_tempo: got %h expected 0000", tempo_bcd); end
    checks++; if (tempo_zero !== 1'b1) begin errors++; $display("FAIL clr_zero: got %b expected 1", tempo_zero); end
    checks++; if (tecla_bcd !== 4'd3) begin errors++; $display("FAIL clr_tecla: got %h expected 3", tecla_bcd); end
    repeat (2) tick();
    teclado = '0; repeat (6) tick();
    // reset while the capture is pending, key still held
    teclado = 10'b1 << 8; repeat (DEB) tick();
    #1 reset = 1'b1; #1;
    model_reset();
    #1 reset = 1'b0;
    for (int i = 0; i < 10 && first < 0; i++) begin
      tick();
      if (digito_pronto) first = i;
    end
    checks++; if (first != DEB) begin errors++; $display("FAIL rst_redebounce: got %0d expected %0d", first, DEB); end
    checks++; if (tempo_bcd !== 16'h0008) begin errors++; $display("FAIL rst_recapture: got %h expected 0008", tempo_bcd); end
    // asynchronous reset between edges while digito_pronto is high
    #1 reset = 1'b1; #1;
    model_reset();
    checks++; if (digito_pronto !== 1'b0) begin errors++; $display("FAIL arst_pronto: got %b expected 0", digito_pronto); end
    checks++; if (tempo_bcd !== 16'h0000) begin errors++; $display("FAIL arst_tempo: got %h expected 0000", tempo_bcd); end
    checks++; if (tecla_bcd !== 4'h0) begin errors++; $display("FAIL arst_tecla: got %h expected 0", tecla_bcd); end
    checks++; if (tempo_zero !== 1'b1) begin errors++; $display("FAIL arst_zero: got %b expected 1", tempo_zero); end
    #1 reset = 1'b0;
    teclado = '0; repeat (6) tick();
    $display("test_limpar_reset: tempo=%h", tempo_bcd);
  endtask

  task automatic test_random();
    logic prev = 1'b0;
    int   r, hold;
    for (int b = 0; b < 90; b++) begin
      r = $urandom_range(0, 9);
      if (r < 2)      teclado = '0;
      else if (r < 8) teclado = 10'b1 << $urandom_range(0, 9);
      else            teclado = 10'($urandom);
      enablen = ($urandom_range(0, 7) == 0);
      hold = $urandom_range(1, 8);
      for (int h = 0; h < hold; h++) begin
        limpar = ($urandom_range(0, 19) == 0);
        tick();
        checks++; if (digito_pronto !== m_pronto) begin errors++; $display("FAIL rnd_pronto b%0d: got %b expected %b", b, digito_pronto, m_pronto); end
        checks++; if (tempo_bcd !== m_tempo) begin errors++; $display("FAIL rnd_tempo b%0d: got %h expected %h", b, tempo_bcd, m_tempo); end
        checks++; if (tecla_bcd !== m_tecla) begin errors++; $display("FAIL rnd_tecla b%0d: got %h expected %h", b, tecla_bcd, m_tecla); end
        checks++; if (tempo_zero !== (m_tempo == 16'h0)) begin errors++; $display("FAIL rnd_zero b%0d: got %b expected %b", b, tempo_zero, (m_tempo == 16'h0)); end
        checks++; if (tempo_invalido !== (m_tempo[7:4] > 4'd5)) begin errors++; $display("FAIL rnd_invalido b%0d: got %b expected %b", b, tempo_invalido, (m_tempo[7:4] > 4'd5)); end
        checks++; if (prev && digito_pronto) begin errors++; $display("FAIL rnd_pulse_width b%0d: got 1 expected 0", b); end
        prev = digito_pronto;
      end
      $display("test_random burst %0d: teclado=%b enablen=%b tempo=%h", b, teclado, enablen, tempo_bcd);
    end
    limpar = 1'b0; enablen = 1'b0; teclado = '0;
  endtask

  initial begin
    test_reset();
    test_single_key();
    test_sequence();
    test_bounce();
    test_priority();
    test_enable();
    test_limpar_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
